muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the execute stage, directly downstream of regfile.
//  Consumes the two read operands (rd1/rd2) and funct3, then returns a 32-bit result plus a destination tag to writeback.
//  Uses a start/busy/done handshake so the pipeline can stall while an operation runs.
// PARAMETERS
//  WIDTH  32  operand/result width; only 32 is supported (counter and special cases sized for it)
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      asynchronous, active-high reset
//  start    in   1      launch operation; sampled only in IDLE or DONE
//  flush    in   1      abort in-flight op (pipeline kill), synchronous
//  op       in   3      funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  a        in   WIDTH  operand rs1 (regfile rd1)
//  b        in   WIDTH  operand rs2 (regfile rd2)
//  rd_in    in   5      destination register tag
//  busy     out  1      op in progress; stall upstream
//  done     out  1      one-cycle pulse: result/rd_out valid
//  result   out  WIDTH  result, held until next accepted start
//  rd_out   out  5      tag captured with start, held with result
// BEHAVIOUR
//  - Reset (async): state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.
//  - FSM: IDLE, CALC, DONE.
//    IDLE/DONE + start -> CALC, or -> DONE for fast-path ops; else DONE -> IDLE.
//    CALC: counter 31..0, one iteration per cycle; at 0 -> DONE.
//  - Start accepted at edge t: a, b, op, rd_in are latched. Later changes to the inputs are ignored.
//  - Normal latency:
//    busy=1 for cycles t+1..t+32 (CALC).
//    done=1 and result valid in cycle t+33 (DONE).
//    busy=0 in DONE.
//  - Back-to-back: start in the DONE cycle is accepted; the next op begins with no idle gap.
//  - Start while busy=1 is ignored (no queueing).
//  - MUL*: shift-add over 64-bit product. Signed operands are converted to magnitude and sign-corrected at the end.
//    MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits.
//  - DIV*: restoring divide on magnitudes; the quotient takes the sign of a^b and the remainder takes the sign of a.
//  - Fast path: IDLE->DONE directly, done at t+1, no CALC.
//    b==0: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = a.
//    DIV a=32'h8000_0000, b=-1: quotient 32'h8000_0000; REM returns 0.
//  - flush=1 at any edge:
//    next state IDLE, busy=0, done=0 next cycle.
//    result/rd_out keep their previous values.
//    flush beats start on the same edge (start dropped).
//  - Reset asserted mid-operation aborts immediately to reset values; no done pulse.
//  - done is never asserted for two consecutive cycles on the same op.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//    MUL/MULH/MULHSU/MULHU use a single-cycle combinational multiply.
//    Path is IDLE->DONE, done at t+1, busy never asserted.
//    Divide is unchanged.
//  Not defined: all multiplies take the 32-iteration CALC path (done at t+33).
// TESTING
//  1. MUL a=7, b=-3 -> done at t+33, result=32'hFFFF_FFEB; rd_in=5 -> rd_out=5.
//  2. MULHU a=b=32'hFFFF_FFFF -> result=32'hFFFF_FFFE. MULH same operands -> 0.
//  3. DIV a=-20, b=3 -> 32'hFFFF_FFFA. REM same operands -> 32'hFFFF_FFFE. Both done at t+33.
//  4. DIVU b=0 -> result FFFF_FFFF at t+1. REM a=32'h8000_0000, b=-1 -> 0 at t+1.
//  5. start DIV, flush at t+10 -> busy=0 at t+11, no done; the following MULHSU start completes normally.
//  6. Back-to-back: start MUL in the DONE cycle -> second done exactly 33 cycles later.
//     Assert reset at t+5 of a DIV -> all outputs 0 immediately.
//     With MULDIV_FAST_MUL_EN: MUL 6*7 -> result=42 at t+1, busy stays 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit in the execute stage. It takes the two
// register-file read operands plus funct3, runs a 32-step shift-add multiply
// or restoring divide, and hands a 32-bit result and destination tag to
// writeback. A start/busy/done handshake lets the pipeline stall meanwhile.
//
// Ports
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high reset
//   start   in   1      launch an operation (sampled only in IDLE or DONE)
//   flush   in   1      synchronous abort of the in-flight op; beats start
//   op      in   3      funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU
//                               4 DIV 5 DIVU 6 REM 7 REMU
//   a       in   WIDTH  rs1 operand
//   b       in   WIDTH  rs2 operand
//   rd_in   in   5      destination tag, captured with start
//   busy    out  1      CALC in progress
//   done    out  1      one-cycle pulse, result/rd_out valid
//   result  out  WIDTH  result, held until the next op completes
//   rd_out  out  5      tag belonging to result
//
// Configuration
//   MULDIV_FAST_MUL_EN  when defined, all multiplies complete through a
//                       single-cycle combinational multiplier (IDLE->DONE).
//                       Divides always use the iterative path.
//
// WIDTH must be 32: the iteration counter and divide special cases are sized
// for it.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign-correct a finished magnitude computation.
  //   multiply: f_acc holds the 64-bit magnitude product
  //   divide:   f_acc holds {remainder, quotient} magnitudes
  function automatic logic [WIDTH-1:0] finalize(
    input logic [2:0]         f_op,
    input logic               f_neg,
    input logic [2*WIDTH-1:0] f_acc
  );
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   part;
    prod = f_neg ? -f_acc : f_acc;
    part = f_op[1] ? f_acc[2*WIDTH-1:WIDTH] : f_acc[WIDTH-1:0];
    if (!f_op[2]) begin
      return (f_op == 3'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end
    return f_neg ? -part : part;
  endfunction

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // |b|: multiplicand or divisor
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         rd_out_q, rd_out_d;

  // ---------------------------------------------------------------------------
  // Operand decode for the op being offered on the inputs
  // ---------------------------------------------------------------------------
  logic             a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, fast_hit;
  logic [WIDTH-1:0] fast_div_res, fast_mul_res;

  // Signed rs1: MUL, MULH, MULHSU, DIV, REM. Signed rs2: same minus MULHSU.
  assign a_sgn  = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
  assign b_sgn  = a_sgn && (op != 3'd2);
  assign a_neg  = a_sgn & a[WIDTH-1];
  assign b_neg  = b_sgn & b[WIDTH-1];
  assign mag_a  = a_neg ? -a : a;
  assign mag_b  = b_neg ? -b : b;
  // Remainder follows the dividend's sign; everything else follows a^b.
  assign neg_in = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = (b == '0);
  // Signed overflow only for DIV/REM (op[0]==0 within the divide group).
  assign div_ovf  = !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  // Divide by zero: quotient all ones, remainder a. Overflow: quotient is a
  // (0x8000_0000), remainder 0.
  assign fast_div_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  logic [2*WIDTH-1:0] mag_prod;
  assign mag_prod     = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
  assign fast_mul_res = finalize(op, neg_in, mag_prod);
`else
  localparam bit FastMul = 1'b0;
  assign fast_mul_res = '0;
`endif

  assign fast_hit = op[2] ? (div_zero | div_ovf) : FastMul;

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm on the held state
  // ---------------------------------------------------------------------------
  // Multiply: multiplier sits in acc low half and shifts out LSB first while
  // the partial product grows into the high half (33-bit add keeps the carry).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: {rem, dividend} shifts left one bit; trial-subtract the
  // divisor, and a missing borrow means the quotient bit is 1.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = !div_diff[WIDTH];
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] step;
  assign step = op_q[2] ? div_next : mul_next;

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves one
    // unassigned; otherwise synthesis infers latches.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    if (flush) begin
      // Kill wins over start; the visible result/tag are left untouched.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_d   = op;
            neg_d  = neg_in;
            rd_d   = rd_in;
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            if (fast_hit) begin
              state_d  = ST_DONE;
              result_d = op[2] ? fast_div_res : fast_mul_res;
              rd_out_d = rd_in;
            end else begin
              state_d = ST_CALC;
              cnt_d   = 5'(WIDTH - 1);
            end
          end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_d = step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d  = ST_DONE;
            result_d = finalize(op_q, neg_q, step);
            rd_out_d = rd_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
